alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue-side controller for the 32-bit combinational ALU. Accepts one instruction per handshake.
//  Reads operands from a local register file and drives the ALU operand/opcode/Cin inputs.
//  Captures Result/Flags, writes the result back and holds the architectural flag register.
//  Sits between the instruction source and the ALU; the ALU instance lives outside this block.
// PARAMETERS
//  NREGS   8   number of 32-bit registers (power of 2, >=2); R0 reads 0, writes to R0 dropped
//  RIDX_W  3   register index width = $clog2(NREGS)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       instruction valid
//  in_ready     out  1       controller can accept (high only in IDLE)
//  in_opcode    in   5       ALU opcode (0x00..0x0E legal)
//  in_rd        in   RIDX_W  destination register
//  in_ra        in   RIDX_W  source A register
//  in_rb        in   RIDX_W  source B register (ignored when in_use_imm)
//  in_use_imm   in   1       1: B operand = in_imm
//  in_imm       in   32      immediate B operand
//  alu_a        out  32      registered operand A to ALU
//  alu_b        out  32      registered operand B to ALU
//  alu_opcode   out  5       registered opcode to ALU
//  alu_cin      out  1       registered carry-in = flags_q[2] (C) at accept time
//  alu_result   in   32      ALU Result (combinational from alu_* outputs)
//  alu_flags    in   4       ALU Flags {V,C,N,Z}
//  wb_valid     out  1       1-cycle pulse: result written to wb_rd
//  wb_rd        out  RIDX_W  written register index
//  wb_data      out  32      written value
//  flags_q      out  4       architectural flags {V,C,N,Z}
//  illegal_op   out  1       1-cycle pulse: opcode > 0x0E dropped
//  dbg_addr     in   RIDX_W  debug read address
//  dbg_data     out  32      debug read data (combinational, R0 = 0)
// BEHAVIOUR
//  Reset: all registers, flags_q, alu_*, wb_*, illegal_op = 0; state IDLE; in_ready = 1 after reset.
//  FSM: IDLE -(in_valid & in_ready)-> EXEC -> WB -> IDLE; 3 cycles per instruction, no overlap.
//  Accept (T): latch alu_a = R[ra], alu_b = use_imm ? imm : R[rb], alu_opcode, alu_cin = flags_q[2], rd.
//  EXEC (T+1): ALU settles; at end of cycle, capture alu_result/alu_flags into internal regs.
//  WB (T+2): wb_valid = 1, R[rd] <= result (unless rd==0), flags_q <= captured flags; in_ready = 1 in T+3.
//  Illegal opcode (>0x0E): accepted, no EXEC; illegal_op pulses in T+1; no WB, flags unchanged.
//  Operands read at accept: an instruction sourcing a register written by its predecessor sees the new value.
//  R0 writes: wb_valid still pulses and wb_data shows the value, but R0 stays 0.
//  rst_n asserted mid-instruction: instruction lost, all state to reset values, no wb_valid.
//  in_valid while busy: ignored (in_ready = 0); the source holds in_valid and fields stable until accepted.
// CONFIGURATION
//  `ALU_ISSUE_DIV0_TRAP_EN defined: DIV (0x03) with alu_b == 0 enters state TRAP instead of WB.
//   TRAP: no register write, flags_q <= captured flags (V=1), trap output = 1, in_ready = 0.
//   TRAP exits to IDLE on trap_clr input pulse. Extra ports: trap out 1, trap_clr in 1.
//  Undefined: no trap ports; DIV-by-zero completes normally (writes 0, V=1).
// STRUCTURE
//  Package alu_pkg: opcode localparams OP_ADD..OP_RCR, OP_MAX = 5'h0E, flag bit indices FLG_V=3, FLG_C=2, FLG_N=1, FLG_Z=0.
//  Package alu_pkg: FSM state encoding {IDLE, EXEC, WB, TRAP}.
//  Sub-module alu_regfile: NREGS x 32; 2 combinational read ports + debug port; 1 sync write port; async reset.
// TESTING
//  Reset mid-EXEC -> no wb_valid; flags_q = 0; in_ready = 1 in the first cycle after release.
//  R1=5, R2=3, ADD rd=3 -> wb_valid at T+2, wb_data=8, flags_q=0000; dbg R3 = 8.
//  R1=3, SUB rd=4, imm=5 -> wb_data=0xFFFFFFFE; flags_q: V=0, C=0, N=1, Z=0 (4'b0010).
//  flags C=1, R1=0x80000000, RCL imm=1 -> alu_cin=1; wb_data=0x00000001; flags_q C=1.
//  Opcode 0x1F -> illegal_op pulse at T+1; no wb_valid; flags_q and regfile unchanged.
//  DIV R1/imm 0 with TRAP_EN -> trap=1, R[rd] unchanged, flags_q V=1, in_ready=0 until trap_clr.
//  DIV R1/imm 0 without TRAP_EN -> wb_data=0, V=1.
//  Back-to-back ADD rd=3 then ADD ra=3 -> second instruction uses the updated R3.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : opcode map, flag bit positions and issue-FSM state encoding      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h02;
  localparam logic [4:0] OP_DIV = 5'h03;
  localparam logic [4:0] OP_AND = 5'h04;
  localparam logic [4:0] OP_OR  = 5'h05;
  localparam logic [4:0] OP_XOR = 5'h06;
  localparam logic [4:0] OP_NOT = 5'h07;
  localparam logic [4:0] OP_SHL = 5'h08;
  localparam logic [4:0] OP_SHR = 5'h09;
  localparam logic [4:0] OP_SAR = 5'h0A;
  localparam logic [4:0] OP_ROL = 5'h0B;
  localparam logic [4:0] OP_ROR = 5'h0C;
  localparam logic [4:0] OP_RCL = 5'h0D;
  localparam logic [4:0] OP_RCR = 5'h0E;
  localparam logic [4:0] OP_MAX = 5'h0E;

  localparam int FLG_V = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_regfile : NREGS x 32 register file, R0 hard-wired to zero,             |
// |               two combinational read ports, debug read port, 1 write port  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra_addr,
  input  logic [RIDX_W-1:0] rb_addr,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [31:0]       ra_data,
  output logic [31:0]       rb_data,
  output logic [31:0]       dbg_data,
  input  logic              we,
  input  logic [RIDX_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);

  logic [31:0] w_word [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_word[gi] = '0;
    end else begin : g_word
      logic [31:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (we && (wr_addr == RIDX_W'(gi))) begin
          r_q <= wr_data;
        end
      end
      assign w_word[gi] = r_q;
    end
  end

  assign ra_data  = w_word[ra_addr];
  assign rb_data  = w_word[rb_addr];
  assign dbg_data = w_word[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_ctrl : issue/writeback controller for the external 32-bit ALU.   |
// | Optional ALU_ISSUE_DIV0_TRAP_EN: divide-by-zero traps until trap_clr.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_ra,
  input  logic [RIDX_W-1:0] in_rb,
  input  logic              in_use_imm,
  input  logic [31:0]       in_imm,
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  output logic              trap,
  input  logic              trap_clr,
`endif
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [31:0]       alu_result,
  input  logic [3:0]        alu_flags,
  output logic              wb_valid,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [31:0]       wb_data,
  output logic [3:0]        flags_q,
  output logic              illegal_op,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_legal;
  logic              r_wb_valid;
  logic [RIDX_W-1:0] r_rd;
  logic [31:0]       r_res;
  logic [3:0]        r_flg;
  logic [31:0]       w_ra_data;
  logic [31:0]       w_rb_data;

  assign w_legal = op_legal(in_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          // Illegal opcodes are consumed here and never reach EXEC.
          if (w_legal) begin
            w_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        w_next = ST_WB;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
        if ((alu_opcode == OP_DIV) && (alu_b == '0)) begin
          w_next = ST_TRAP;
        end
`endif
      end
      ST_WB: begin
        w_next = ST_IDLE;
      end
      ST_TRAP: begin
`ifdef ALU_ISSUE_DIV0_TRAP_EN
        if (trap_clr) begin
          w_next = ST_IDLE;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_cin    <= 1'b0;
      r_rd       <= '0;
      r_res      <= '0;
      r_flg      <= '0;
      r_wb_valid <= 1'b0;
      flags_q    <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= w_accept && !w_legal;
      r_wb_valid <= (r_state == ST_EXEC) && (w_next == ST_WB);
      if (w_accept) begin
        alu_a      <= w_ra_data;
        alu_b      <= in_use_imm ? in_imm : w_rb_data;
        alu_opcode <= in_opcode;
        alu_cin    <= flags_q[FLG_C];
        r_rd       <= in_rd;
      end
      if (r_state == ST_EXEC) begin
        r_res <= alu_result;
        r_flg <= alu_flags;
      end
      if ((r_state == ST_WB) || (r_state == ST_TRAP)) begin
        flags_q <= r_flg;
      end
    end
  end

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign trap = (r_state == ST_TRAP);
`endif

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_rd;
  assign wb_data  = r_res;

  // Write lands at the end of WB, so an instruction accepted next reads it.
  alu_regfile #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (in_ra),
    .rb_addr  (in_rb),
    .dbg_addr (dbg_addr),
    .ra_data  (w_ra_data),
    .rb_data  (w_rb_data),
    .dbg_data (dbg_data),
    .we       (r_wb_valid),
    .wr_addr  (r_rd),
    .wr_data  (r_res)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue_ctrl : scoreboard bench for alu_issue_ctrl with an ALU model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [2:0]  in_rd = '0, in_ra = '0, in_rb = '0;
  logic        in_use_imm = 1'b0;
  logic [31:0] in_imm = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_opcode;
  logic        alu_cin;
  logic [3:0]  alu_flags;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags_q;
  logic        illegal_op;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
  logic        trap;
  logic        trap_clr = 1'b0;
`endif

  typedef struct {
    bit          ill;
    logic [2:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        me;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] m_reg [8];
  logic [3:0]  m_flags = '0;

  alu_issue_ctrl #(.NREGS(8), .RIDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    .trap       (trap),
    .trap_clr   (trap_clr),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flags_q    (flags_q),
    .illegal_op (illegal_op),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: returns {V,C,N,Z, result}.
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    logic        v, c;
    r = '0; v = 1'b0; c = 1'b0; t = '0;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        t = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = t[31:0]; c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_DIV: begin
        if (b == '0) begin r = '0; v = 1'b1; end
        else         r = a / b;
      end
      OP_RCL: begin
        r = {a[30:0], cin}; c = a[31];
      end
      default: r = a ^ b;
    endcase
    return {v, c, r[31], (r == '0), r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reg(input logic [2:0] idx);
    dbg_addr = idx;
    #1;
    check("dbg_reg", dbg_data, m_reg[idx]);
  endtask

  // Drives one instruction, scores it, and (unless trapping) waits for in_ready.
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input bit imm_en, input logic [31:0] imm,
                       input bit trap_exp);
    logic [31:0] a, b;
    logic [35:0] fr;
    logic        cin;
    exp_t        e;
    bit          legal;
    @(negedge clk);
    in_opcode = op; in_rd = rd; in_ra = ra; in_rb = rb;
    in_use_imm = imm_en; in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    legal = (op <= 5'h0E);
    a   = m_reg[ra];
    b   = imm_en ? imm : m_reg[rb];
    cin = m_flags[2];
    fr  = alu_fn(op, a, b, cin);
    if (!trap_exp) begin
      e.ill = !legal; e.rd = rd; e.data = fr[31:0];
      e.cyc = cyc + (legal ? 2 : 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (legal) begin
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      check("alu_opcode", alu_opcode, op);
      check("alu_cin", alu_cin, cin);
      if (!trap_exp && rd != 0) m_reg[rd] = fr[31:0];
      m_flags = fr[35:32];
    end
    if (trap_exp) return;
    for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
    check("ready_after", in_ready, 1);
    check("flags_q", flags_q, m_flags);
  endtask

  always @(negedge clk) begin
    if (wb_valid || illegal_op) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {wb_valid, illegal_op}, 2'b00);
      end else begin
        me = exp_q.pop_front();
        check("out_kind", {wb_valid, illegal_op}, me.ill ? 2'b01 : 2'b10);
        check("out_cycle", cyc, me.cyc);
        if (!me.ill) begin
          check("wb_rd", wb_rd, me.rd);
          check("wb_data", wb_data, me.data);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      check("out_missing", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags_q, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_alu", {alu_a, alu_b[4:0], alu_opcode, alu_cin}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_post_rst", in_ready, 1);

    // R1=5, R2=3, R3=R1+R2
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 32'd5, 0);
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1, 32'd3, 0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 0, 32'd0, 0);
    check("add_flags", flags_q, 4'b0000);
    check_reg(3'd3);
    check("add_r3", dbg_data, 32'd8);

    // R1=3, R4 = R1 - 5
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 32'd3, 0);
    issue(OP_SUB, 3'd4, 3'd1, 3'd0, 1, 32'd5, 0);
    check("sub_flags", flags_q, 4'b0010);
    check_reg(3'd4);

    // R0 write is reported but dropped
    issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1, 32'h1234, 0);
    check_reg(3'd0);

    // RCL through a set carry
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 32'h8000_0000, 0);
    issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1, 32'hFFFF_FFFF, 0);
    issue(OP_ADD, 3'd0, 3'd6, 3'd0, 1, 32'd1, 0);
    check("carry_set", flags_q[2], 1);
    issue(OP_RCL, 3'd2, 3'd1, 3'd0, 1, 32'd1, 0);
    check_reg(3'd2);
    check("rcl_r2", dbg_data, 32'd1);
    check("rcl_c", flags_q[2], 1);

    // Illegal opcode: pulse only, no state change
    issue(5'h1F, 3'd2, 3'd1, 3'd0, 1, 32'd7, 0);
    check_reg(3'd2);

    // Regular divide, then divide by zero
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 32'd40, 0);
    issue(OP_DIV, 3'd5, 3'd1, 3'd0, 1, 32'd8, 0);
    check_reg(3'd5);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    issue(OP_DIV, 3'd5, 3'd1, 3'd0, 1, 32'd0, 1);
    @(negedge clk);
    @(negedge clk);
    check("trap_set", trap, 1);
    check("trap_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("trap_hold", {trap, in_ready}, 2'b10);
    check("trap_flags", flags_q, m_flags);
    check("trap_v", flags_q[3], 1);
    check_reg(3'd5);
    trap_clr = 1'b1;
    @(posedge clk);
    #1;
    trap_clr = 1'b0;
    check("trap_clr", {trap, in_ready}, 2'b01);
`else
    issue(OP_DIV, 3'd5, 3'd1, 3'd0, 1, 32'd0, 0);
    check_reg(3'd5);
    check("div0_r5", dbg_data, 32'd0);
    check("div0_v", flags_q[3], 1);
`endif

    // Back-to-back dependency through R3
    issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1, 32'd7, 0);
    issue(OP_ADD, 3'd7, 3'd3, 3'd0, 1, 32'd1, 0);
    check_reg(3'd7);
    check("dep_r7", dbg_data, 32'd48);

    // Reset in EXEC: instruction lost, everything cleared
    @(negedge clk);
    in_opcode = OP_SUB; in_rd = 3'd6; in_ra = 3'd0; in_use_imm = 1'b1;
    in_imm = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_flags = '0;
    check("midrst_flags", flags_q, 0);
    check("midrst_wb", wb_valid, 0);
    check_reg(3'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", in_ready, 1);
    check_reg(3'd6);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
